// File: rtl/aes_key_sched_seq.sv
// Sequential AES key expansion: one schedule word per clock, all round keys held
// in registers and read out combinationally by round index for a decryption core.
module aes_key_sched_seq #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [32*Nk-1:0] key_in,
  output logic            busy,
  output logic            keys_valid,
  input  logic [3:0]      rd_round,
  output logic [127:0]    rd_key
);

  localparam int NW = 4*(Nr+1);
  localparam int IW = $clog2(NW);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   idx;
  logic [2:0]      kpos;      // idx mod Nk, kept as a counter to avoid a divider
  logic [7:0]      rcon;
  logic [Nk-1:0][31:0] win;   // win[0] = w[idx-Nk], win[Nk-1] = w[idx-1]
  logic [31:0]     w [NW];
  logic [31:0]     temp, new_w;
  logic            load, last;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  assign load       = start && (state != EXPAND);
  assign last       = (state == EXPAND) && (idx == IW'(NW-1));
  assign busy       = (state == EXPAND);
  assign keys_valid = (state == DONE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = EXPAND;
      EXPAND:  if (last)  state_nx = DONE;
      DONE:    if (start) state_nx = EXPAND;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    temp = win[Nk-1];
    if (kpos == 3'd0)
      temp = sub_word({win[Nk-1][23:0], win[Nk-1][31:24]}) ^ {rcon, 24'h0};
    else if (Nk > 6 && kpos == 3'd4)
      temp = sub_word(win[Nk-1]);
    new_w = win[0] ^ temp;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
      kpos  <= '0;
      rcon  <= 8'h01;
    end else begin
      state <= state_nx;
      if (load) begin
        idx  <= IW'(Nk);
        kpos <= '0;
        rcon <= 8'h01;
      end else if (state == EXPAND) begin
        idx  <= idx + 1'b1;
        kpos <= (kpos == 3'(Nk-1)) ? 3'd0 : kpos + 3'd1;
        if (kpos == 3'd0) rcon <= xtime(rcon);
      end
    end
  end

  // Word storage is left uncleared; keys_valid gates every read.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < Nk; k++) begin
        win[k] <= key_in[32*(Nk-k)-1 -: 32];
        w[k]   <= key_in[32*(Nk-k)-1 -: 32];
      end
    end else if (state == EXPAND) begin
      win    <= {new_w, win[Nk-1:1]};
      w[idx] <= new_w;
    end
  end

  always_comb begin
    rd_key = '0;
    for (int r = 0; r <= Nr; r++)
      if (keys_valid && rd_round == 4'(r))
        rd_key = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  end

endmodule

// File: tb/tb_aes_key_sched_seq.sv
// Scoreboard bench for aes_key_sched_seq: AES-128 and AES-256 instances, directed
// FIPS-197 vectors, restart/ignore/reset-abort scenarios and latency tracking.
module tb_aes_key_sched_seq;

  logic clk = 1'b0, reset = 1'b0;
  logic start4 = 1'b0, start8 = 1'b0;
  logic [127:0] key4 = '0;
  logic [255:0] key8 = '0;
  logic [3:0] rnd4 = '0, rnd8 = '0;
  logic busy4, kv4, busy8, kv8;
  logic [127:0] rk4, rk8;

  aes_key_sched_seq #(.Nk(4), .Nr(10)) u4 (
    .clk(clk), .reset(reset), .start(start4), .key_in(key4),
    .busy(busy4), .keys_valid(kv4), .rd_round(rnd4), .rd_key(rk4));

  aes_key_sched_seq #(.Nk(8), .Nr(14)) u8 (
    .clk(clk), .reset(reset), .start(start8), .key_in(key8),
    .busy(busy8), .keys_valid(kv8), .rd_round(rnd8), .rd_key(rk8));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [127:0] K128  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  typedef struct {
    bit           d8;
    logic [127:0] key;
    logic         bsy;
    logic         kv;
    string        nm;
  } exp_t;

  exp_t chk_q[$];
  int   lat4_q[$], lat8_q[$];
  int   sc4 = 0, sc8 = 0;
  int   total = 0, passed = 0;
  event chk_ev;

  task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: round-key reads presented by the stimulus side
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      while (chk_q.size() > 0) begin
        e = chk_q.pop_front();
        if (e.d8) begin
          cmp({e.nm, ".key"}, rk8, e.key);
          cmp({e.nm, ".busy"}, 128'(busy8), 128'(e.bsy));
          cmp({e.nm, ".kv"}, 128'(kv8), 128'(e.kv));
        end else begin
          cmp({e.nm, ".key"}, rk4, e.key);
          cmp({e.nm, ".busy"}, 128'(busy4), 128'(e.bsy));
          cmp({e.nm, ".kv"}, 128'(kv4), 128'(e.kv));
        end
      end
    end
  end

  // Monitor: keys_valid rising edges against expected latency
  initial begin
    bit p4 = 1'b0, p8 = 1'b0;
    forever begin
      @(negedge clk);
      if (kv4 && !p4) begin
        if (lat4_q.size() == 0) begin
          total++;
          $display("FAIL lat4: keys_valid rose with no expansion pending");
        end else cmp("lat4", 128'(cyc - sc4 - 1), 128'(lat4_q.pop_front()));
      end
      if (kv8 && !p8) begin
        if (lat8_q.size() == 0) begin
          total++;
          $display("FAIL lat8: keys_valid rose with no expansion pending");
        end else cmp("lat8", 128'(cyc - sc8 - 1), 128'(lat8_q.pop_front()));
      end
      p4 = kv4;
      p8 = kv8;
    end
  end

  task automatic check(input bit d8, input logic [3:0] r, input logic [127:0] k,
                       input logic b, input logic v, input string nm);
    if (d8) rnd8 = r; else rnd4 = r;
    #1;
    chk_q.push_back('{d8: d8, key: k, bsy: b, kv: v, nm: nm});
    ->chk_ev;
    #1;
  endtask

  task automatic pulse4(input logic [127:0] k, input bit push);
    @(negedge clk);
    key4 = k; start4 = 1'b1;
    if (push) begin sc4 = cyc; lat4_q.push_back(40); end
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic pulse8(input logic [255:0] k);
    @(negedge clk);
    key8 = k; start8 = 1'b1;
    sc8 = cyc; lat8_q.push_back(52);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait_kv(input bit d8);
    for (int n = 0; n < 100 && !(d8 ? kv8 : kv4); n++) @(negedge clk);
    if (!(d8 ? kv8 : kv4)) begin
      total++;
      $display("FAIL wait_kv%0d: keys_valid got 0 expected 1 within 100 cycles", d8 ? 8 : 4);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check(0, 4'd0, '0, 1'b0, 1'b0, "rst4");
    check(1, 4'd0, '0, 1'b0, 1'b0, "rst8");
    reset = 1'b1;
    @(negedge clk);
    check(0, 4'd0, '0, 1'b0, 1'b0, "idle4");

    // AES-128 expansion with an ignored start mid-expansion
    pulse4(K128, 1'b1);
    check(0, 4'd0, '0, 1'b1, 1'b0, "exp4");
    repeat (8) @(negedge clk);
    pulse4(128'hffeeddccbbaa99887766554433221100, 1'b0);
    wait_kv(0);
    check(0, 4'd0,  K128, 1'b0, 1'b1, "k128_r0");
    check(0, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605, 1'b0, 1'b1, "k128_r1");
    check(0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0, 1'b1, "k128_r10");
    check(0, 4'd11, '0, 1'b0, 1'b1, "k128_r11");
    check(0, 4'd15, '0, 1'b0, 1'b1, "k128_r15");

    // Restart from DONE with an all-zero key
    pulse4('0, 1'b1);
    check(0, 4'd10, '0, 1'b1, 1'b0, "restart_drop");
    wait_kv(0);
    check(0, 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, 1'b0, 1'b1, "zero_r10");
    check(0, 4'd1,  128'h62636363626363636263636362636363, 1'b0, 1'b1, "zero_r1");

    // Reset partway through expansion, then a clean rerun
    pulse4(K128, 1'b1);
    repeat (19) @(negedge clk);
    #2 reset = 1'b0;
    lat4_q.delete();
    check(0, 4'd0, '0, 1'b0, 1'b0, "rst_abort");
    @(negedge clk);
    reset = 1'b1;
    pulse4(K128, 1'b1);
    check(0, 4'd10, '0, 1'b1, 1'b0, "rerun_busy");
    wait_kv(0);
    check(0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0, 1'b1, "rerun_r10");
    check(0, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605, 1'b0, 1'b1, "rerun_r1");

    // AES-256
    pulse8(K256);
    check(1, 4'd14, '0, 1'b1, 1'b0, "exp8");
    wait_kv(1);
    check(1, 4'd0,  128'h000102030405060708090a0b0c0d0e0f, 1'b0, 1'b1, "k256_r0");
    check(1, 4'd1,  128'h101112131415161718191a1b1c1d1e1f, 1'b0, 1'b1, "k256_r1");
    check(1, 4'd2,  128'ha573c29fa176c498a97fce93a572c09c, 1'b0, 1'b1, "k256_r2");
    check(1, 4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36, 1'b0, 1'b1, "k256_r14");
    check(1, 4'd15, '0, 1'b0, 1'b1, "k256_r15");

    repeat (2) @(negedge clk);
    cmp("lat_q_drained", 128'(lat4_q.size() + lat8_q.size()), 128'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/aes_key_sched_seq.md
AES_KEY_SCHED_SEQ -- requirements
Module: aes_key_sched_seq

Interface
REQ-001 SHALL have parameter Nk, default 4, meaning key length in 32-bit words (4, 6 or 8).
REQ-002 SHALL have parameter Nr, default 10, meaning round count (10, 12 or 14, paired with Nk 4, 6 or 8).
REQ-003 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to expand key_in.
REQ-006 SHALL have port key_in  input  32*Nk  cipher key, FIPS-197 byte order, first key byte in MSBs.
REQ-007 SHALL have port busy  output  1  high while expansion is in progress.
REQ-008 SHALL have port keys_valid  output  1  high when all round keys are stored and readable.
REQ-009 SHALL have port rd_round  input  4  round-key index for the decryption core, 0..Nr.
REQ-010 SHALL have port rd_key  output  128  round key rd_round; word w[4r] in [127:96], w[4r+3] in [31:0].

Function
REQ-011 SHALL implement FSM states IDLE, EXPAND and DONE.
REQ-012 SHALL store 4*(Nr+1) 32-bit words w[] in registers.
REQ-013 In IDLE or DONE, start=1 at a clock edge SHALL load w[0..Nk-1] from key_in, set i=Nk, load Rcon=0x01, and enter EXPAND.
REQ-014 In EXPAND, each edge SHALL write exactly one word: w[i]=w[i-Nk]^temp, then increment i.
REQ-015 temp SHALL be SubWord(RotWord(w[i-1]))^{Rcon,24'h0} when i mod Nk==0, SubWord(w[i-1]) when Nk>6 and i mod Nk==4, and w[i-1] otherwise.
REQ-016 Rcon SHALL advance by GF(2^8) doubling (xtime, reduction 0x1B) after each use, giving 01,02,04,08,10,20,40,80,1B,36,...
REQ-017 SubWord SHALL apply the FIPS-197 forward S-box to each of the 4 bytes.
REQ-018 After the edge that writes w[4*(Nr+1)-1], the FSM SHALL enter DONE.
REQ-019 Latency from the start edge to keys_valid=1 SHALL be exactly 4*(Nr+1)-Nk cycles: 40 for Nk=4, 46 for Nk=6, 52 for Nk=8.
REQ-020 busy SHALL equal (state==EXPAND).
REQ-021 keys_valid SHALL equal (state==DONE).
REQ-022 start while in EXPAND SHALL be ignored; expansion continues unchanged.
REQ-023 start in DONE SHALL restart: keys_valid drops on that edge and the new key is expanded.
REQ-024 rd_key SHALL be combinational from rd_round and stored words.
REQ-025 rd_key SHALL be 128'h0 when keys_valid=0 or rd_round>Nr.
REQ-026 key_in SHALL be sampled only on the accepting start edge; later changes SHALL have no effect.

Reset
REQ-027 reset=0 SHALL immediately force state=IDLE, i=0, Rcon=0x01, busy=0, keys_valid=0 and rd_key=0, regardless of clk.
REQ-028 Reset during EXPAND SHALL abort expansion; the next start SHALL perform a full expansion.
REQ-029 Stored words need not be cleared by reset; REQ-025 masks them.

Verification
REQ-030 Nk=4/Nr=10, key 2b7e151628aed2a6abf7158809cf4f3c, start one cycle -> keys_valid rises 40 cycles later; rd_round 0 -> key itself; 1 -> a0fafe1788542cb123a339392a6c7605; 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-031 Nk=8/Nr=14, key 000102...1e1f, start -> keys_valid after 52 cycles; rd_round 14 -> 24fc79ccbf0979e9371ac23c6d68de36.
REQ-032 start pulsed again 10 cycles into EXPAND with a different key_in -> ignored; results still match REQ-030 at cycle 40.
REQ-033 reset low at cycle 20 of EXPAND -> busy=0, keys_valid=0, rd_key=0 at once; restart after release -> REQ-030 results 40 cycles later.
REQ-034 In DONE, rd_round=11 -> rd_key=0; start with an all-zero key -> keys_valid=0 for 40 cycles; then rd_round 10 -> b4ef5bcb3e92e21123e951cf6f8f188e.
